// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - RV32I instruction formats, opcodes and immediate-range helper.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_t;

  // The decoder side names the same selector imm_src_t.
  typedef instr_fmt_t imm_src_t;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // True when v survives truncation to a signed field of the given width.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// rtl/instr_encoder_imm_packer.sv - scatters an immediate into its RV32I bit positions.
// Range-check output exists only with INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder_imm_packer
  import instr_encoder_pkg::*;
(
  input  instr_fmt_t  fmt,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  ,
  output logic        range_ok
`endif
);

  always_comb begin
    imm_bits = '0;
    case (fmt)
      FMT_I:   imm_bits = {imm[11:0], 20'b0};
      FMT_S:   imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      FMT_B:   imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      FMT_U:   imm_bits = {imm[31:12], 12'b0};
      FMT_J:   imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      default: imm_bits = '0;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  always_comb begin
    range_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: range_ok = fits_signed(imm, 12);
      FMT_B:        range_ok = fits_signed(imm, 13) && !imm[0];
      FMT_U:        range_ok = (imm[11:0] == 12'b0);
      FMT_J:        range_ok = fits_signed(imm, 21) && !imm[0];
      default:      range_ok = 1'b1;
    endcase
  end
`endif

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs RV32I fields into words and streams them to instruction memory.
// Optional immediate range check: INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              done_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        fmt_i,
  input  logic [6:0]        op_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [31:0]       imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic              err_o
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_WORD = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [1:0]  state;
  logic [31:0] fifo_mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        accept, pop;
  instr_fmt_t  fmt;
  logic [31:0] imm_bits, word;

  assign fmt        = instr_fmt_t'(fmt_i);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign in_ready_o = (state == ST_RUN) && !fifo_full;
  assign accept     = in_valid_i && in_ready_o;
  assign mem_we_o   = !fifo_empty;
  assign pop        = mem_we_o && mem_ready_i;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = (state == ST_DONE);
  // Gate the read so wdata is 0 whenever nothing is queued.
  assign mem_wdata_o = fifo_empty ? 32'b0 : fifo_mem[rd_ptr[PW-1:0]];

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic range_ok;

  instr_encoder_imm_packer u_imm_packer (
    .fmt      (fmt),
    .imm      (imm_i),
    .imm_bits (imm_bits),
    .range_ok (range_ok)
  );
`else
  instr_encoder_imm_packer u_imm_packer (
    .fmt      (fmt),
    .imm      (imm_i),
    .imm_bits (imm_bits)
  );
`endif

  always_comb begin
    word = imm_bits | {25'b0, op_i};
    case (fmt)
      FMT_I:        word = word | {12'b0, rs1_i, funct3_i, rd_i, 7'b0};
      FMT_S, FMT_B: word = word | {7'b0, rs2_i, rs1_i, funct3_i, 12'b0};
      FMT_U, FMT_J: word = word | {20'b0, rd_i, 7'b0};
      default:      word = word | {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, 7'b0};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (accept && !start_i) fifo_mem[wr_ptr[PW-1:0]] <= word;
  end

  // start_i restarts the session and overrides any concurrent push, pop or done_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_addr_o <= BASE;
      ovf_o      <= 1'b0;
    end else if (start_i) begin
      state      <= ST_RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_addr_o <= BASE;
      ovf_o      <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        mem_addr_o <= mem_addr_o + ADDR_W'(4);
        if (mem_addr_o == LAST_WORD) ovf_o <= 1'b1;
      end
      case (state)
        ST_IDLE:  state <= ST_IDLE;
        ST_RUN:   if (done_i) state <= ST_FLUSH;
        ST_FLUSH: if (fifo_empty) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                err_o <= 1'b0;
    else if (start_i)           err_o <= 1'b0;
    else if (accept && !range_ok) err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed and randomized bench for instr_encoder with a scoreboard model.
module tb_instr_encoder;

  localparam int ADDR_W = 10;
  localparam int ASPACE = 1 << ADDR_W;

  logic              clk, rst_n, start, done_in, in_valid, in_ready;
  logic [2:0]        fmt;
  logic [6:0]        op;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [31:0]       imm;
  logic              mem_we, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done_o, ovf, err;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          m_addr = 0;
  bit          m_ovf = 0;
  bit          m_err = 0;
  bit          rand_ready = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .done_i(done_in),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .fmt_i(fmt), .op_i(op),
    .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .busy_o(busy), .done_o(done_o), .ovf_o(ovf), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                                      input logic [6:0] fn7, input logic [31:0] im);
    case (f)
      3'd1:    return {im[11:0], s1, fn3, d, o};
      3'd2:    return {im[11:5], s2, s1, fn3, im[4:0], o};
      3'd3:    return {im[12], im[10:5], s2, s1, fn3, im[4:1], im[11], o};
      3'd4:    return {im[31:12], d, o};
      3'd5:    return {im[20], im[10:1], im[11], im[19:12], d, o};
      default: return {fn7, s2, s1, fn3, d, o};
    endcase
  endfunction

  function automatic bit imm_ok(input logic [2:0] f, input logic [31:0] im);
    int v;
    v = $signed(im);
    case (f)
      3'd1, 3'd2: return (v >= -2048) && (v <= 2047);
      3'd3:       return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
      3'd4:       return (im % 4096) == 0;
      3'd5:       return (v >= -(1 << 20)) && (v < (1 << 20)) && (v % 2 == 0);
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic exp_err();
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    return m_err;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", exp_q.size(), 1);
      end else begin
        check("wdata", mem_wdata, exp_q.pop_front());
        check("waddr", mem_addr, m_addr);
        if (m_addr == ASPACE - 4) m_ovf = 1'b1;
        m_addr = (m_addr + 4) % ASPACE;
      end
    end
  end

  task automatic do_start();
    mem_ready = 1'b0;
    start = 1'b1;
    exp_q.delete();
    m_addr = 0;
    m_ovf = 1'b0;
    m_err = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                      input logic [6:0] fn7, input logic [31:0] im, input bit dn,
                      input bit use_lit, input logic [31:0] lit);
    bit got;
    got = 1'b0;
    fmt = f; op = o; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
    in_valid = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        done_in = dn;
        exp_q.push_back(use_lit ? lit : enc(f, o, d, s1, s2, fn3, fn7, im));
        if (!imm_ok(f, im)) m_err = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    done_in = 1'b0;
    check("accept", got, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    bit          seen;
    logic [31:0] r;
    logic [31:0] rim;
    start = 0; done_in = 0; in_valid = 0; mem_ready = 0;
    fmt = 0; op = 0; rd = 0; rs1 = 0; rs2 = 0; f3 = 0; f7 = 0; imm = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed encodings from the reference examples.
    do_start();
    mem_ready = 1'b1;
    @(negedge clk);
    check("run_busy", busy, 1);
    check("run_ready", in_ready, 1);
    @(posedge clk); #1;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0, 1, 32'h00500093);
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0, 1, 32'h002081B3);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 0, 1, 32'h0020A423);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 0, 1, 32'hFE208EE3);
    send(3'd5, 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 0, 1, 32'h008000EF);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 0, 1, 32'h123452B7);
    drain();

    // Backpressure: two entries fill the FIFO, the third must wait.
    do_start();
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 0, 0, 0);
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 0, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    check("full_ready", in_ready, 0);
    check("stall_we", mem_we, 1);
    check("stall_addr", mem_addr, 0);
    check("stall_wdata", mem_wdata, exp_q[0]);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_addr_hold", mem_addr, 0);
    check("stall_wdata_hold", mem_wdata, exp_q[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 0, 0, 0);
    drain();

    // done_i together with the last accept, then FLUSH -> DONE -> IDLE.
    send(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h20, 32'd0, 1, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("done_pulse", seen, 1);
    check("done_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;

    // Random bundles with random backpressure; more than 256 writes force a wrap.
    do_start();
    rand_ready = 1'b1;
    for (int n = 0; n < 260; n++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       rim = r;
        1:       rim = {{20{r[11]}}, r[11:0]};
        2:       rim = {{19{r[12]}}, r[12:1], 1'b0};
        default: rim = {r[31:12], 12'b0};
      endcase
      send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), rim, 0, 0, 0);
    end
    rand_ready = 1'b0;
    mem_ready = 1'b1;
    drain();
    @(negedge clk);
    check("ovf_model", ovf, m_ovf);
    check("ovf_wrapped", ovf, 1);
    check("err_random", err, exp_err());
    @(posedge clk); #1;

    // start_i during FLUSH drops the queued words.
    do_start();
    send(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 0, 0, 0);
    send(3'd1, 7'h13, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 0, 0, 0);
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 1);
    check("flush_ready", in_ready, 0);
    check("flush_we", mem_we, 1);
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    check("restart_we", mem_we, 0);
    check("restart_addr", mem_addr, 0);
    check("restart_ready", in_ready, 1);
    check("restart_ovf", ovf, 0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    send(3'd4, 7'h17, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 0, 0, 0);
    drain();

    // Out-of-range I immediate: word still written truncated.
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 0, 1, 32'h80000093);
    drain();
    @(negedge clk);
    check("err_imm2048", err, exp_err());
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a session.
    mem_ready = 1'b0;
    send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 0, 0, 0);
    @(negedge clk);
    check("pending_we", mem_we, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
